eca_rule_sequencer: RTL and testbench
=====================================

ECA_RULE_SEQUENCER -- requirements
Module: eca_rule_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of cells in the ring (legal 3..64).
REQ-002 SHALL have parameter GEN_W, default 8, width of the generation count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels the run in progress.
REQ-007 SHALL have port rule  input  8  3-input truth table, MSB-first: output for neighbourhood k = rule[7-k].
REQ-008 SHALL have port seed  input  WIDTH  initial cell pattern.
REQ-009 SHALL have port gens  input  GEN_W  number of generations to compute.
REQ-010 SHALL have port cells  output  WIDTH  current generation register.
REQ-011 SHALL have port gen_cnt  output  GEN_W  generations committed this run.
REQ-012 SHALL have port busy  output  1  high in EVAL and COMMIT.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port stable  output  1  fixed point reached (see REQ-030).

Function
REQ-015 FSM states SHALL be IDLE, EVAL, COMMIT, DONE.
REQ-016 IDLE with start=1 SHALL load cells<=seed, latch rule and gens, clear gen_cnt and cell index, and go to EVAL; if gens==0, go to DONE instead.
REQ-017 EVAL SHALL evaluate one cell per cycle, index 0 upward, writing the result to a shadow next-state register.
REQ-018 Neighbourhood for cell i SHALL be k={cells[(i+1) mod WIDTH], cells[i], cells[(i-1) mod WIDTH]}, wrapping at both ring ends.
REQ-019 After index WIDTH-1, EVAL SHALL go to COMMIT.
REQ-020 COMMIT SHALL copy shadow to cells and increment gen_cnt; if the new gen_cnt equals the latched gens, go to DONE, else return to EVAL with index 0.
REQ-021 DONE SHALL assert done for exactly one cycle and return to IDLE; cells and gen_cnt SHALL hold until the next accepted start.
REQ-022 Latency SHALL be exactly gens*(WIDTH+1)+1 cycles from the start-sampling edge to the done cycle, for gens>0.
REQ-023 start outside IDLE SHALL be ignored; changes to rule, seed or gens during a run SHALL have no effect.
REQ-024 abort in EVAL or COMMIT SHALL return to IDLE on the next edge without done; cells SHALL keep the last committed generation; abort SHALL take priority over COMMIT.
REQ-025 gen_cnt SHALL not wrap, since gens is bounded by GEN_W.

Reset
REQ-026 reset SHALL force IDLE and clear cells, shadow, gen_cnt, busy, done, stable and the latched rule to 0.
REQ-027 reset SHALL take priority over start and abort and SHALL be honoured in every state, including mid-generation.

Configuration
REQ-028 Macro ECA_STABLE_EN SHALL compile in fixed-point detection.
REQ-029 With ECA_STABLE_EN, COMMIT with shadow==cells SHALL still commit and increment gen_cnt, set stable=1, and go to DONE early; stable SHALL clear on the next accepted start.
REQ-030 Without ECA_STABLE_EN, stable SHALL be tied to 0 and every run SHALL compute all gens generations.

Structure
REQ-031 A shared package eca_pkg SHALL hold the FSM state enum and the constants RULE_W=8 and NBHD_W=3.
REQ-032 A sub-module eca_rule_lut SHALL implement the combinational rule lookup (rule, 3-bit neighbourhood -> 1 bit) and SHALL be instantiated once, time-shared across all cells.

Verification (WIDTH=8)
REQ-033 The bench SHALL check: rule=8'h44, seed=8'h01, gens=1 -> cells=8'h02, gen_cnt=1, done exactly 10 cycles after start.
REQ-034 The bench SHALL check: rule=8'h44, seed=8'h01, gens=8 -> cells=8'h01 after the ring wrap, done exactly 73 cycles after start.
REQ-035 The bench SHALL check: rule=8'h44, seed=8'h03, gens=1 -> cells=8'h04; seed=8'hFF, gens=1 -> cells=8'h00.
REQ-036 The bench SHALL check: gens=0, seed=8'hA5 -> done the cycle after start, cells=8'hA5, busy never high.
REQ-037 The bench SHALL check: abort during generation 2 of a gens=5 run (rule 8'h44, seed 8'h01) -> IDLE, no done, cells=8'h02; then reset mid-EVAL -> all outputs 0.
REQ-038 With ECA_STABLE_EN, the bench SHALL check: rule=8'h00, seed=8'h5A, gens=10 -> stable=1, gen_cnt=2, early done; without the macro, gen_cnt=10, stable=0.

Source files
------------

// File: rtl/eca_pkg.sv
// Shared definitions for the elementary cellular automaton rule sequencer.
package eca_pkg;

    localparam int unsigned RULE_W = 8;
    localparam int unsigned NBHD_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } eca_state_e;

endpackage : eca_pkg

// File: rtl/eca_rule_lut.sv
// Combinational rule lookup: one 3-cell neighbourhood in, next cell value out.
// Rule bits are MSB-first, so neighbourhood k selects rule[7-k] (== rule[~k]).
module eca_rule_lut
    import eca_pkg::*;
(
    input  logic [RULE_W-1:0] rule_i,
    input  logic [NBHD_W-1:0] nbhd_i,
    output logic              next_cell_c
);

    // Inverting the 3-bit neighbourhood gives the MSB-first bit position.
    always_comb begin
        next_cell_c = rule_i[~nbhd_i];
    end

endmodule : eca_rule_lut

// File: rtl/eca_rule_sequencer.sv
// Ring-topology elementary cellular automaton sequencer. Evaluates one cell per
// cycle through a single shared rule LUT into a shadow register, then commits
// the whole generation at once.
// Optional feature: define ECA_STABLE_EN to stop early at a fixed point.
module eca_rule_sequencer
    import eca_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GEN_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RULE_W-1:0] rule,
    input  logic [WIDTH-1:0]  seed,
    input  logic [GEN_W-1:0]  gens,
    output logic [WIDTH-1:0]  cells,
    output logic [GEN_W-1:0]  gen_cnt,
    output logic              busy,
    output logic              done,
    output logic              stable
);

    localparam int unsigned       IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WIDTH - 1);

    eca_state_e        state_q, state_d;
    logic [WIDTH-1:0]  cells_q, shadow_q;
    logic [GEN_W-1:0]  gen_cnt_q, gens_q;
    logic [RULE_W-1:0] rule_q;
    logic [IDX_W-1:0]  idx_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]  idx_up_c, idx_dn_c;
    logic [NBHD_W-1:0] nbhd_c;
    logic              next_cell_c;
    logic [GEN_W-1:0]  gen_next_c;
    logic              last_gen_c;
    logic              fixed_pt_c;

    // Ring neighbour indices and the neighbourhood of the cell being evaluated.
    always_comb begin
        idx_up_c   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        idx_dn_c   = (idx_q == '0) ? IDX_LAST : idx_q - IDX_W'(1);
        nbhd_c     = {cells_q[idx_up_c], cells_q[idx_q], cells_q[idx_dn_c]};
        gen_next_c = gen_cnt_q + GEN_W'(1);
        last_gen_c = (gen_next_c == gens_q);
    end

`ifdef ECA_STABLE_EN
    logic stable_q;

    // A generation that reproduces itself is a fixed point.
    always_comb begin
        fixed_pt_c = (shadow_q == cells_q);
    end
    assign stable = stable_q;
`else
    always_comb begin
        fixed_pt_c = 1'b0;
    end
    assign stable = 1'b0;
`endif

    // Single rule LUT shared by every cell in turn.
    eca_rule_lut u_lut (
        .rule_i      (rule_q),
        .nbhd_i      (nbhd_c),
        .next_cell_c (next_cell_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort wins over a pending commit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (gens == '0) ? DONE : EVAL;
                end
            end
            EVAL: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == IDX_LAST) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_gen_c || fixed_pt_c) begin
                    state_d = DONE;
                end else begin
                    state_d = EVAL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so busy/done can be registered.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            EVAL, COMMIT: busy_d = 1'b1;
            DONE:         done_d = 1'b1;
            default:      ;
        endcase
    end

    // Datapath: load on start, shadow fill in EVAL, generation commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cells_q   <= '0;
            shadow_q  <= '0;
            gen_cnt_q <= '0;
            gens_q    <= '0;
            rule_q    <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ECA_STABLE_EN
            stable_q  <= 1'b0;
`endif
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cells_q   <= seed;
                        rule_q    <= rule;
                        gens_q    <= gens;
                        gen_cnt_q <= '0;
                        idx_q     <= '0;
`ifdef ECA_STABLE_EN
                        stable_q  <= 1'b0;
`endif
                    end
                end
                EVAL: begin
                    if (!abort) begin
                        shadow_q[idx_q] <= next_cell_c;
                        idx_q           <= idx_up_c;
                    end
                end
                COMMIT: begin
                    if (!abort) begin
                        cells_q   <= shadow_q;
                        gen_cnt_q <= gen_next_c;
                        idx_q     <= '0;
`ifdef ECA_STABLE_EN
                        if (fixed_pt_c) begin
                            stable_q <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign cells   = cells_q;
    assign gen_cnt = gen_cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule : eca_rule_sequencer

// File: tb/tb_eca_rule_sequencer.sv
// Self-checking bench for eca_rule_sequencer (WIDTH=8, GEN_W=8), scoreboard
// driven by a behavioural ring-automaton model.
module tb_eca_rule_sequencer;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned GEN_W  = 8;
    localparam int          BUDGET = 2000;

    logic             clk = 1'b0;
    logic             reset, start, abort;
    logic [7:0]       rule;
    logic [WIDTH-1:0] seed;
    logic [GEN_W-1:0] gens;
    logic [WIDTH-1:0] cells;
    logic [GEN_W-1:0] gen_cnt;
    logic             busy, done, stable;

    typedef struct {
        logic [7:0] cells;
        logic [7:0] gen_cnt;
        logic       stable;
        int         latency;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    eca_rule_sequencer #(.WIDTH(WIDTH), .GEN_W(GEN_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .rule    (rule),
        .seed    (seed),
        .gens    (gens),
        .cells   (cells),
        .gen_cnt (gen_cnt),
        .busy    (busy),
        .done    (done),
        .stable  (stable)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One generation: cell i sees {c[i+1], c[i], c[i-1]} on the ring, output rule[7-k].
    function automatic logic [7:0] model_step(input logic [7:0] r, input logic [7:0] c);
        logic [7:0] n;
        int         k;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            k    = {29'd0, c[(i + 1) % 8], c[i], c[(i + 7) % 8]};
            n[i] = r[7 - k];
        end
        return n;
    endfunction

    function automatic exp_t model_run(input logic [7:0] r, input logic [7:0] s, input logic [7:0] g);
        exp_t       e;
        logic [7:0] cur;
        logic [7:0] nxt;
        cur       = s;
        e.gen_cnt = '0;
        e.stable  = 1'b0;
        for (int n = 0; n < int'(g); n++) begin
            nxt       = model_step(r, cur);
            e.gen_cnt = e.gen_cnt + 8'd1;
`ifdef ECA_STABLE_EN
            if (nxt == cur) begin
                e.stable = 1'b1;
                break;
            end
`endif
            cur = nxt;
        end
        e.cells   = cur;
        e.latency = int'(e.gen_cnt) * (WIDTH + 1) + 1;
        return e;
    endfunction

    // Push the expectation, start a run, wait for done, pop and compare.
    task automatic run_case(input logic [7:0] r, input logic [7:0] s, input logic [7:0] g,
                            input bit disturb);
        exp_t e;
        bit   got;
        bit   busy_seen;
        int   lat;
        exp_q.push_back(model_run(r, s, g));
        @(negedge clk);
        rule  = r;
        seed  = s;
        gens  = g;
        start = 1'b1;
        got       = 1'b0;
        busy_seen = 1'b0;
        lat       = 0;
        for (int cnt = 1; cnt <= BUDGET; cnt++) begin
            @(negedge clk);
            if (cnt == 1) start = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (done) begin
                got = 1'b1;
                lat = cnt;
                break;
            end
            if (disturb) begin
                rule  = 8'($urandom);
                seed  = 8'($urandom);
                gens  = 8'($urandom);
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!got) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("cells", 64'(cells), 64'(e.cells));
            check("gen_cnt", 64'(gen_cnt), 64'(e.gen_cnt));
            check("stable", 64'(stable), 64'(e.stable));
            check("latency", 64'(lat), 64'(e.latency));
            check("busy_at_done", 64'(busy), 64'd0);
            if (g == 8'd0) check("busy_gens0", 64'(busy_seen), 64'd0);
            @(negedge clk);
            check("done_pulse", 64'(done), 64'd0);
            check("hold_cells", 64'(cells), 64'(e.cells));
        end
    endtask

    initial begin
        int done_hits;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rule  = '0;
        seed  = '0;
        gens  = '0;
        repeat (3) @(negedge clk);
        check("rst_cells", 64'(cells), 64'd0);
        check("rst_gen_cnt", 64'(gen_cnt), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_stable", 64'(stable), 64'd0);
        reset = 1'b0;

        // Directed cases, including single step, full ring wrap and gens=0.
        run_case(8'h44, 8'h01, 8'd1, 1'b0);
        check("shift_1", 64'(cells), 64'h02);
        run_case(8'h44, 8'h01, 8'd8, 1'b1);
        check("wrap_8", 64'(cells), 64'h01);
        run_case(8'h44, 8'h03, 8'd1, 1'b0);
        check("seed03", 64'(cells), 64'h04);
        run_case(8'h44, 8'hFF, 8'd1, 1'b0);
        check("seedFF", 64'(cells), 64'h00);
        run_case(8'h44, 8'hA5, 8'd0, 1'b0);
        check("gens0", 64'(cells), 64'hA5);
        run_case(8'h00, 8'h5A, 8'd10, 1'b0);
        run_case(8'd30, 8'h10, 8'd4, 1'b1);

        // Random rules/seeds with input disturbance during some runs.
        for (int i = 0; i < 4; i++) begin
            run_case(8'($urandom), 8'($urandom), 8'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
        end

        // Abort during generation 2 of a 5-generation run.
        @(negedge clk);
        rule  = 8'h44;
        seed  = 8'h01;
        gens  = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort_pre_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        done_hits = 0;
        for (int c = 0; c < 60; c++) begin
            if (done) done_hits++;
            @(negedge clk);
        end
        check("abort_no_done", 64'(done_hits), 64'd0);
        check("abort_cells", 64'(cells), 64'h02);
        check("abort_gen_cnt", 64'(gen_cnt), 64'd1);

        // Reset mid-EVAL, asserted together with start and abort.
        start = 1'b1;
        gens  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("mid_rst_cells", 64'(cells), 64'd0);
        check("mid_rst_gen_cnt", 64'(gen_cnt), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_stable", 64'(stable), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("post_rst_idle", 64'(busy), 64'd0);

        // Recovery after reset.
        run_case(8'h44, 8'h01, 8'd2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_eca_rule_sequencer
